// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e : FSM state encoding (idle / shifting / result-valid)
//   clog2   : ceiling log2, used to size the bit counter
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the only arithmetic in the serial adder datapath.
// Ports:
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + ci one bit per cycle, LSB first.
// An accepted start loads the operands and carry-in, WIDTH shift cycles
// follow, then a single DONE cycle pulses done. Result stays held until
// the next accepted start.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request an addition (accepted only while idle)
//   a, b  : operands, sampled on the accepting edge
//   ci    : carry-in, sampled on the accepting edge
//   busy  : high in SHIFT and DONE
//   done  : one-cycle pulse when sum/co are valid
//   sum   : a + b + ci modulo 2^WIDTH
//   co    : carry-out
//   ovf   : two's-complement overflow (only with SERIAL_ADDER_OVF_EN defined)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  full_adder u_full_adder (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // New sum bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB while the MSB is being processed.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  // The carry flop only moves on start or shift, so it already holds co stable after done.
  assign co   = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=8 instance for directed cases
// and a WIDTH=3 instance swept over every operand/carry combination.
// Build with SERIAL_ADDER_OVF_EN defined to also check ovf.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       ci8;
  logic       busy8, done8, co8;
  logic [7:0] sum8;

  logic       start3;
  logic [2:0] a3, b3;
  logic       ci3;
  logic       busy3, done3, co3;
  logic [2:0] sum3;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] sum;
    logic       co;
    logic       ovf;
  } exp8_t;

  exp8_t      q8[$];
  logic [3:0] q3[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .ci    (ci8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .co    (co8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start3),
    .a     (a3),
    .b     (b3),
    .ci    (ci3),
    .busy  (busy3),
    .done  (done3),
    .sum   (sum3),
    .co    (co3)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    exp8_t      e;
    logic [8:0] full;
    full  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    e.sum = full[7:0];
    e.co  = full[8];
    e.ovf = (a[7] == b[7]) && (full[7] != a[7]);
    return e;
  endfunction

  // Waits (on falling edges) for done8; lat = number of falling edges waited.
  task automatic wait_done8(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // Drives one start pulse, queues the expected result, then scrambles operands.
  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a8     = a;
    b8     = b;
    ci8    = ci;
    start8 = 1'b1;
    q8.push_back(model8(a, b, ci));
    @(negedge clk);
    start8 = 1'b0;
    a8     = ~a;
    b8     = ~b;
    ci8    = ~ci;
  endtask

  // Waits for done, checks latency and scoreboard head, and that the result is held.
  task automatic finish8(input string tag, input int exp_lat, input bit check_idle);
    int    lat;
    bit    ok;
    exp8_t e;
    wait_done8(lat, ok);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_in_done"}, 32'(busy8), 32'd1);
      if (q8.size() == 0) begin
        check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = q8.pop_front();
        check({tag, "_sum"}, 32'(sum8), 32'(e.sum));
        check({tag, "_co"}, 32'(co8), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf8), 32'(e.ovf));
`endif
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
        if (check_idle) begin
          check({tag, "_idle_after"}, 32'(busy8), 32'd0);
        end
        check({tag, "_sum_held"}, 32'(sum8), 32'(e.sum));
        check({tag, "_co_held"}, 32'(co8), 32'(e.co));
      end
    end
  endtask

  initial begin
    int seen;
    int lat;
    bit ok;
    logic [3:0] e3;

    rst_n  = 1'b0;
    start8 = 1'b1;  // reset must win over start
    a8     = 8'h11;
    b8     = 8'h22;
    ci8    = 1'b0;
    start3 = 1'b0;
    a3     = '0;
    b3     = '0;
    ci3    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_co", 32'(co8), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf8), 32'd0);
`endif
    start8 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("rst_start_ignored", 32'(busy8), 32'd0);

    // Zero operands: done visible 9 cycles after start is applied.
    start8_op(8'h00, 8'h00, 1'b0);
    check("zero_busy_after_accept", 32'(busy8), 32'd1);
    finish8("zero", 8, 1'b1);

    start8_op(8'hA5, 8'h5A, 1'b1);
    finish8("a5_5a_ci", 8, 1'b1);
    start8_op(8'hFF, 8'h01, 1'b0);
    finish8("ff_01", 8, 1'b1);
    start8_op(8'h7F, 8'h01, 1'b0);
    finish8("7f_01", 8, 1'b1);
    start8_op(8'hFF, 8'hFF, 1'b0);
    finish8("ff_ff", 8, 1'b1);
    start8_op(8'h80, 8'h80, 1'b1);
    finish8("80_80_ci", 8, 1'b1);
    start8_op(8'h3C, 8'h41, 1'b0);
    finish8("3c_41", 8, 1'b1);

    // Second start three cycles after acceptance must be ignored.
    start8_op(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8     = 8'hFF;
    b8     = 8'hFF;
    ci8    = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    finish8("ignore_busy_start", 5, 1'b1);

    // Start held high: one accepted request per 10 cycles.
    q8.push_back(model8(8'h0F, 8'hF0, 1'b1));
    q8.push_back(model8(8'h55, 8'h66, 1'b0));
    a8     = 8'h0F;
    b8     = 8'hF0;
    ci8    = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    a8     = 8'h55;
    b8     = 8'h66;
    ci8    = 1'b0;
    finish8("b2b_first", 8, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_second_accepted", 32'(busy8), 32'd1);
    finish8("b2b_second", 8, 1'b1);

    // Reset while bit 4 is in flight aborts the addition silently.
    a8     = 8'h3C;
    b8     = 8'hC3;
    ci8    = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_co", 32'(co8), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    start8_op(8'h3C, 8'hC3, 1'b1);
    finish8("after_abort", 8, 1'b1);

    // WIDTH=3: every a, b, ci combination.
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a3     = 3'(ia);
          b3     = 3'(ib);
          ci3    = ic[0];
          start3 = 1'b1;
          q3.push_back(4'(ia + ib + ic));
          @(negedge clk);
          start3 = 1'b0;
          a3     = ~a3;
          b3     = ~b3;
          lat    = 0;
          ok     = 1'b0;
          for (int w = 0; w < 20; w++) begin
            if (done3) begin
              ok = 1'b1;
              break;
            end
            @(negedge clk);
            lat++;
          end
          if (!ok || lat != 3) begin
            check("w3_latency", 32'(lat), 32'd3);
          end
          if (q3.size() != 0) begin
            e3 = q3.pop_front();
            check($sformatf("w3_a%0d_b%0d_c%0d", ia, ib, ic), 32'({co3, sum3}), 32'(e3));
          end
          @(negedge clk);
        end
      end
    end
    check("w3_scoreboard_empty", 32'(q3.size()), 32'd0);
    check("w8_scoreboard_empty", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
